// File: rtl/vmem_responder.sv
// Responder side of the processor's virtual memory bus: decodes BASE_ADDR-relative
// word offsets into keyboard FIFO, tick timer, LEDs, score, sprite positions and an LFSR.
module vmem_responder #(
    parameter int          BASE_ADDR  = 5000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TICK_DIV   = 50000,
    parameter logic [31:0] LFSR_SEED  = 32'hACE12468
) (
    input  logic         system_clock,
    input  logic         reset,
    input  logic         wren_virtual,
    input  logic [16:0]  address_virtual,
    input  logic [31:0]  data_virtual,
    output logic [31:0]  q_virtual,
    input  logic         ps2_key_valid,
    input  logic [7:0]   ps2_key_data,
    output logic [9:0]   leds,
    output logic [15:0]  score,
    output logic [127:0] sprite_pos
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [16:0]      BASE       = 17'(BASE_ADDR);
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(TICK_DIV - 1);
    localparam logic [31:0]      LFSR_TAPS  = 32'h8020_0003;

    localparam logic [16:0] OFF_KEY_STATUS = 17'd0;
    localparam logic [16:0] OFF_KEY_DATA   = 17'd1;
    localparam logic [16:0] OFF_TIMER      = 17'd2;
    localparam logic [16:0] OFF_LED        = 17'd3;
    localparam logic [16:0] OFF_SCORE      = 17'd4;
    localparam logic [16:0] OFF_RANDOM     = 17'd5;
    localparam logic [16:0] OFF_SPRITE0    = 17'd8;
    localparam logic [16:0] OFF_SPRITE3    = 17'd11;

    logic [16:0] offset;
    logic        in_range;
    logic        mapped;
    logic        sel_sprite;

    logic        prev_wren;
    logic [16:0] prev_addr;
    logic        wr_commit;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] key_count;
    logic             overflow;
    logic             fifo_empty;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;
    logic             ovf_set;
    logic             ovf_clr;

    logic [31:0]      timer;
    logic [PRE_W-1:0] prescale;

    logic [31:0] lfsr;
    logic [31:0] lfsr_next;

    logic [9:0]  led_reg;
    logic [15:0] score_reg;
    logic [31:0] sprite_reg [4];

    // ---------------- address decode ----------------
    assign offset     = address_virtual - BASE;
    assign in_range   = (address_virtual >= BASE);
    assign sel_sprite = in_range && (offset >= OFF_SPRITE0) && (offset <= OFF_SPRITE3);
    assign mapped     = (in_range && (offset <= OFF_RANDOM)) || sel_sprite;

    // Edge-detect on (wren, address) so a store held over several cycles acts once.
    assign wr_commit = wren_virtual && (!prev_wren || (prev_addr != address_virtual)) && mapped;

    always_ff @(posedge system_clock) begin
        if (!reset) begin
            prev_wren <= 1'b0;
            prev_addr <= '0;
        end else begin
            prev_wren <= wren_virtual;
            prev_addr <= address_virtual;
        end
    end

    // ---------------- keyboard FIFO ----------------
    assign fifo_empty = (key_count == '0);
    assign fifo_full  = (key_count == FIFO_FULL);
    assign do_pop     = wr_commit && (offset == OFF_KEY_DATA) && !fifo_empty;
    assign do_push    = ps2_key_valid && (!fifo_full || do_pop);
    assign ovf_set    = ps2_key_valid && fifo_full && !do_pop;
    assign ovf_clr    = wr_commit && (offset == OFF_KEY_STATUS);

    always_ff @(posedge system_clock) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= ps2_key_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge system_clock) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            key_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   key_count <= key_count + 1'b1;
                2'b01:   key_count <= key_count - 1'b1;
                default: key_count <= key_count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---------------- tick timer ----------------
    // Prescaler is a down-counter; terminal count 0 marks the end of a tick period.
    always_ff @(posedge system_clock) begin
        if (!reset) begin
            timer    <= '0;
            prescale <= PRE_RELOAD;
        end else if (wr_commit && (offset == OFF_TIMER)) begin
            timer    <= data_virtual;
            prescale <= PRE_RELOAD;
        end else if (prescale == '0) begin
            timer    <= timer + 32'd1;
            prescale <= PRE_RELOAD;
        end else begin
            prescale <= prescale - 1'b1;
        end
    end

    // ---------------- LFSR (Galois, x^32+x^22+x^2+x+1) ----------------
    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);

    always_ff @(posedge system_clock) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge system_clock) begin
        if (!reset) begin
            led_reg   <= '0;
            score_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                sprite_reg[i] <= '0;
            end
        end else if (wr_commit) begin
            if (offset == OFF_LED) begin
                led_reg <= data_virtual[9:0];
            end
            if (offset == OFF_SCORE) begin
                score_reg <= data_virtual[15:0];
            end
            if (sel_sprite) begin
                sprite_reg[offset[1:0]] <= data_virtual;
            end
        end
    end

    assign leds  = led_reg;
    assign score = score_reg;

    always_comb begin
        sprite_pos = '0;
        for (int i = 0; i < 4; i++) begin
            sprite_pos[32*i +: 32] = sprite_reg[i];
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        q_virtual = '0;
        if (sel_sprite) begin
            q_virtual = sprite_reg[offset[1:0]];
        end else if (in_range) begin
            case (offset)
                OFF_KEY_STATUS: q_virtual = {26'b0, overflow, 4'(key_count), fifo_empty};
                OFF_KEY_DATA:   q_virtual = fifo_empty ? 32'h0 : {24'b0, fifo_mem[rd_ptr]};
                OFF_TIMER:      q_virtual = timer;
                OFF_LED:        q_virtual = {22'b0, led_reg};
                OFF_SCORE:      q_virtual = {16'b0, score_reg};
                OFF_RANDOM:     q_virtual = lfsr;
                default:        q_virtual = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_responder.sv
// Scoreboard bench for vmem_responder: stimulus queues expected values, a negedge
// monitor pops and compares them against the selected DUT output.
module tb_vmem_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wren_virtual = 1'b0;
    logic [16:0]  address_virtual = '0;
    logic [31:0]  data_virtual = '0;
    logic [31:0]  q_virtual;
    logic         ps2_key_valid = 1'b0;
    logic [7:0]   ps2_key_data = '0;
    logic [9:0]   leds;
    logic [15:0]  score;
    logic [127:0] sprite_pos;

    logic sample_req = 1'b0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    vmem_responder #(
        .BASE_ADDR (5000),
        .FIFO_DEPTH(8),
        .TICK_DIV  (4),
        .LFSR_SEED (32'hACE12468)
    ) dut (
        .system_clock   (clk),
        .reset          (reset),
        .wren_virtual   (wren_virtual),
        .address_virtual(address_virtual),
        .data_virtual   (data_virtual),
        .q_virtual      (q_virtual),
        .ps2_key_valid  (ps2_key_valid),
        .ps2_key_data   (ps2_key_data),
        .leds           (leds),
        .score          (score),
        .sprite_pos     (sprite_pos)
    );

    always #5 clk = ~clk;

    // kind 0: q_virtual, 1: leds, 2: score, 3: sprite slot idx
    always @(negedge clk) begin
        if (sample_req) begin
            logic [31:0] act;
            exp_t        e;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow actual=empty_queue required=entry");
            end else begin
                e = sb_q.pop_front();
                case (e.kind)
                    1:       act = {22'b0, leds};
                    2:       act = {16'b0, score};
                    3:       act = sprite_pos[32*e.idx +: 32];
                    default: act = q_virtual;
                endcase
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic check(input int kind, input int idx, input logic [16:0] a,
                         input logic [31:0] e, input string nm);
        exp_t x;
        x.kind = kind;
        x.idx  = idx;
        x.exp  = e;
        x.name = nm;
        sb_q.push_back(x);
        address_virtual = a;
        sample_req = 1'b1;
        @(posedge clk);
        #1;
        sample_req = 1'b0;
    endtask

    task automatic rd(input logic [16:0] a, input logic [31:0] e, input string nm);
        check(0, 0, a, e, nm);
    endtask

    task automatic cycle_op(input logic w, input logic [16:0] a, input logic [31:0] d,
                            input logic kv, input logic [7:0] kd);
        wren_virtual    = w;
        address_virtual = a;
        data_virtual    = d;
        ps2_key_valid   = kv;
        ps2_key_data    = kd;
        @(posedge clk);
        #1;
        wren_virtual  = 1'b0;
        ps2_key_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [16:0] a, input logic [31:0] d);
        cycle_op(1'b1, a, d, 1'b0, 8'h00);
    endtask

    task automatic push(input logic [7:0] code);
        cycle_op(1'b0, 17'd0, 32'h0, 1'b1, code);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset           = 1'b0;
        wren_virtual    = 1'b0;
        ps2_key_valid   = 1'b0;
        address_virtual = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] drain_exp [8];
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};

        // reset state and LFSR
        do_reset();
        rd(17'd5005, 32'hACE12468, "lfsr_seed");
        rd(17'd5005, 32'h56709234, "lfsr_step1");
        check(1, 0, 17'd0, 32'h0, "leds_reset");
        check(2, 0, 17'd0, 32'h0, "score_reset");
        rd(17'd5000, 32'h1, "status_reset");
        rd(17'd5001, 32'h0, "keydata_empty");

        // FIFO basic and held-store single pop
        push(8'h1C);
        push(8'h23);
        push(8'h1D);
        rd(17'd5000, 32'h6, "status_3");
        rd(17'd5001, 32'h1C, "head_1c");
        wren_virtual    = 1'b1;
        address_virtual = 17'd5001;
        data_virtual    = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        wren_virtual = 1'b0;
        rd(17'd5000, 32'h4, "status_after_held_pop");
        rd(17'd5001, 32'h23, "head_23");

        // overflow, simultaneous clear+overflow, pop+push while full, drain
        do_reset();
        for (int i = 1; i <= 9; i++) push(8'(i));
        rd(17'd5000, 32'h30, "status_overflow");
        rd(17'd5001, 32'h01, "head_after_ovf");
        wr(17'd5000, 32'h0);
        rd(17'd5000, 32'h10, "status_ovf_cleared");
        cycle_op(1'b1, 17'd5000, 32'h0, 1'b1, 8'h55);
        rd(17'd5000, 32'h30, "status_clear_vs_set");
        wr(17'd5000, 32'h0);
        cycle_op(1'b1, 17'd5001, 32'h0, 1'b1, 8'h0A);
        rd(17'd5000, 32'h10, "status_poppush_full");
        for (int i = 0; i < 8; i++) begin
            rd(17'd5001, {24'b0, drain_exp[i]}, $sformatf("drain%0d", i));
            wr(17'd5001, 32'h0);
        end
        rd(17'd5000, 32'h1, "status_drained");
        wr(17'd5001, 32'h0);
        rd(17'd5000, 32'h1, "status_pop_empty");

        // timer
        do_reset();
        repeat (39) @(posedge clk);
        #1;
        rd(17'd5002, 32'd9, "timer_39");
        rd(17'd5002, 32'd10, "timer_40");
        wr(17'd5002, 32'hFFFFFFFF);
        rd(17'd5002, 32'hFFFFFFFF, "timer_loaded");
        repeat (2) @(posedge clk);
        #1;
        rd(17'd5002, 32'h0, "timer_wrap");

        // LED / score / sprites / unmapped
        wr(17'd5003, 32'h3FF);
        wr(17'd5004, 32'h12345);
        wr(17'd5010, 32'hDEADBEEF);
        check(1, 0, 17'd0, 32'h3FF, "leds_out");
        check(2, 0, 17'd0, 32'h2345, "score_out");
        check(3, 2, 17'd0, 32'hDEADBEEF, "sprite2_out");
        check(3, 0, 17'd0, 32'h0, "sprite0_out");
        rd(17'd5003, 32'h3FF, "led_read");
        rd(17'd5004, 32'h2345, "score_read");
        rd(17'd5010, 32'hDEADBEEF, "sprite2_read");
        wr(17'd5006, 32'h55);
        rd(17'd5006, 32'h0, "unmapped6");
        wr(17'd5012, 32'h77);
        rd(17'd5012, 32'h0, "unmapped12");
        wr(17'd4999, 32'h0);
        check(1, 0, 17'd0, 32'h3FF, "leds_after_4999");
        check(2, 0, 17'd0, 32'h2345, "score_after_4999");
        rd(17'd4999, 32'h0, "below_base");

        // reset mid-operation
        do_reset();
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        repeat (6) @(posedge clk);
        #1;
        rd(17'd5002, 32'd3, "timer_before_reset");
        rd(17'd5000, 32'h6, "status_before_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd(17'd5000, 32'h1, "status_after_reset");
        rd(17'd5002, 32'h0, "timer_after_reset");

        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vmem_responder.md
Name: vmem_responder

Overview:
- Responder end of the processor's virtual memory interface.
- Decodes word addresses at BASE_ADDR and above into memory-mapped game peripherals: keyboard scan-code FIFO, millisecond timer, LED register, score register, 4 sprite-position registers and an LFSR random source.
- Serves combinational reads on q_virtual. Commits writes on system_clock.
- Sits between the processor core and the board I/O (PS/2 front end, LEDs, seven-segment driver, VGA sprite renderer).

Parameters:
- BASE_ADDR, 5000, first mapped word address (offsets below are relative to it).
- FIFO_DEPTH, 8, keyboard FIFO entries (power of two, 2..16).
- TICK_DIV, 50000, system_clock cycles per timer tick.
- LFSR_SEED, 32'hACE12468, LFSR reset value (must be nonzero).

Ports:
- system_clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- wren_virtual  in  1  processor write enable.
- address_virtual  in  17  processor word address.
- data_virtual  in  32  processor write data.
- q_virtual  out  32  read data for address_virtual.
- ps2_key_valid  in  1  one-cycle strobe: new scan code present.
- ps2_key_data  in  8  scan code qualified by ps2_key_valid.
- leds  out  10  LED register.
- score  out  16  score register, feeds the seven-segment driver.
- sprite_pos  out  128  sprites 0..3, 32 bits each; sprite n occupies bits [32n+31:32n].

Behaviour:
Reset (reset==0 at a clock edge):
- FIFO empty, overflow flag 0, timer 0, prescaler 0.
- leds 0, score 0, sprite_pos 0, LFSR = LFSR_SEED, write-detect history cleared.

Write detection:
- Registered history prev_wren and prev_addr.
- Commit strobe = wren_virtual & (~prev_wren | prev_addr != address_virtual) & address mapped.
- A store therefore acts exactly once even when wren is held for several system_clock cycles.
- Two consecutive stores to the same address with wren continuously high count as one; software must separate repeated pops with a non-store instruction.

Reads:
- Combinational from address_virtual, zero latency.
- Unmapped or below-BASE addresses return 0.
- Reads have no side effects.

Register map (offset: read / write):
- 0 KEY_STATUS: read = {26'b0, overflow, count[3:0], empty}; any write clears overflow.
- 1 KEY_DATA: read = {24'b0, FIFO head}, or 0 if empty; any write pops one entry (ignored when empty).
- 2 TIMER: read = 32-bit tick count; write loads data_virtual and zeroes the prescaler.
- 3 LED: read/write; low 10 bits are stored, upper read bits are 0.
- 4 SCORE: read/write; low 16 bits are stored.
- 5 RANDOM: read = current LFSR value; writes ignored.
- 8..11 SPRITE0..3: read/write, full 32 bits.
- Offsets 6, 7 and 12 up are unmapped.

FIFO:
- Circular buffer with read pointer, write pointer and count (0..FIFO_DEPTH).
- Push on ps2_key_valid.
- Push when full: code dropped, overflow set (sticky).
- Push and pop in the same cycle:
  - Non-empty, including full: both occur, count unchanged, overflow not set.
  - Empty: push only.
- Pointers wrap modulo FIFO_DEPTH.
- Overflow clear and a new overflow event in the same cycle: overflow ends at 1.

Timer:
- Prescaler counts 0..TICK_DIV-1; timer increments when the prescaler wraps.
- Timer wraps 32'hFFFFFFFF to 0.
- A TIMER write in a wrap cycle takes priority (load wins, no increment).

LFSR:
- Advances every cycle, Galois form, taps 32,22,2,1.
- Never reaches 0.

Outputs:
- leds, score and sprite_pos are registered; they update on the edge after the commit.

Test Plan:
- Reset with reset=0 for 2 cycles, release -> leds=0, score=0, q_virtual at 5000 = 32'h1 (empty), at 5005 = 32'hACE12468.
- Push codes 8'h1C, 8'h23, 8'h1D; read 5000 -> count=3, empty=0 (32'h6); read 5001 -> 32'h1C; store to 5001 with wren held 4 cycles -> one pop only, 5001 then reads 32'h23.
- Push 9 codes 0x01..0x09 with depth 8 -> count=8, overflow=1 (32'h30); head = 0x01; store to 5000 -> 32'h10. Pop and push 0x0A in the same cycle while full -> count stays 8, overflow stays 0.
- With TICK_DIV=4, run 40 cycles from reset -> TIMER reads 10. Store 32'hFFFFFFFF to 5002, run 4 cycles -> TIMER reads 0.
- Store 32'h3FF to 5003, 32'h12345 to 5004, 32'hDEADBEEF to 5010 -> leds=10'h3FF, score=16'h2345, sprite_pos[95:64]=32'hDEADBEEF; read 5006 -> 0; store to 4999 -> no register changes.
- Assert reset while the FIFO holds 3 entries and the timer is nonzero -> next cycle count=0, timer=0, overflow=0.
